// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: state encoding, timing constants
// and the table of song codes the address calculator can actually play.
package song_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_RUN      = 3'd3,
    S_PAUSED   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam int ACK_TIMEOUT_DEFAULT   = 4096;
  localparam int READY_EDGES_PER_START = 2;

  // Bit n set means song code n exists (0-5 and 8-12).
  localparam logic [15:0] VALID_SONG_MASK = 16'b0001_1111_0011_1111;

  function automatic logic is_valid_song(input logic [3:0] code);
    return VALID_SONG_MASK[code];
  endfunction

endpackage

// File: rtl/ready_edge_sync.sv
// Brings the AC97 ready strobe into the clk domain and flags each rising edge.
module ready_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic ready,
  output logic ready_rise
);

  logic sync1, sync2, sync_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= ready;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign ready_rise = sync2 & ~sync_prev;

endmodule

// File: rtl/song_sequencer.sv
// Playback/record control FSM that drives the audio address calculator from
// debounced front-panel buttons and the AC97 ready strobe.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_play,
  input  logic       btn_record,
  input  logic       btn_pause,
  input  logic       btn_stop,
  input  logic [3:0] sw_song,
  input  logic       loop_en,
  input  logic       ready,
  input  logic       song_done,
  output logic       start_song,
  output logic       pause_song,
  output logic       record_mode,
  output logic [3:0] song_choice,
  output logic [2:0] state_dbg,
  output logic       done_pulse,
  output logic       err_pulse
);

  localparam int TO_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX    = '1;
  localparam logic [1:0]      RISE_LAST = 2'(READY_EDGES_PER_START - 1);

  state_t          state, next_state;
  logic            err_next;
  logic            ready_rise;
  logic [1:0]      rise_cnt;
  logic [TO_W-1:0] to_cnt;

  ready_edge_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .ready_rise (ready_rise)
  );

  always_comb begin
    next_state = state;
    err_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (btn_play || btn_record) begin
          if (is_valid_song(sw_song)) next_state = S_START;
          else                        err_next   = 1'b1;
        end
      end
      S_START: begin
        if (btn_stop)                              next_state = S_IDLE;
        else if (ready_rise && rise_cnt == RISE_LAST) next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (btn_stop)              next_state = S_IDLE;
        else if (!song_done)       next_state = S_RUN;
        else if (to_cnt == TO_LAST) begin
          next_state = S_IDLE;
          err_next   = 1'b1;
        end
      end
      S_RUN: begin
        if (btn_stop)       next_state = S_IDLE;
        else if (btn_pause) next_state = S_PAUSED;
        else if (song_done) next_state = S_DONE;
      end
      S_PAUSED: begin
        if (btn_stop)                    next_state = S_IDLE;
        else if (btn_pause || btn_play)  next_state = S_RUN;
      end
      S_DONE: begin
        if (!btn_stop && loop_en && !record_mode) next_state = S_START;
        else                                      next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it exactly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      start_song  <= 1'b0;
      pause_song  <= 1'b1;
      record_mode <= 1'b0;
      song_choice <= 4'd0;
      done_pulse  <= 1'b0;
      err_pulse   <= 1'b0;
      rise_cnt    <= 2'd0;
      to_cnt      <= '0;
    end else begin
      state      <= next_state;
      start_song <= (next_state == S_START);
      pause_song <= (next_state != S_RUN);
      done_pulse <= (next_state == S_DONE);
      err_pulse  <= err_next;
      if (state == S_IDLE && next_state == S_START) begin
        song_choice <= sw_song;
        record_mode <= btn_record;
      end
      if (next_state != state) begin
        rise_cnt <= 2'd0;
        to_cnt   <= '0;
      end else begin
        if (state == S_START && ready_rise) rise_cnt <= rise_cnt + 2'd1;
        if (state == S_WAIT_ACK && to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench: stimulus queues the expected output snapshot for every
// output change it provokes; the monitor compares each observed change.
module tb_song_sequencer;

  typedef struct packed {
    logic [2:0] state;
    logic       start;
    logic       pause;
    logic       rec;
    logic [3:0] choice;
    logic       done;
    logic       err;
  } snap_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_play = 1'b0, btn_record = 1'b0, btn_pause = 1'b0, btn_stop = 1'b0;
  logic [3:0] sw_song = 4'd0;
  logic       loop_en = 1'b0;
  logic       ready = 1'b0;
  logic       song_done = 1'b1;
  logic       start_song, pause_song, record_mode, done_pulse, err_pulse;
  logic [3:0] song_choice;
  logic [2:0] state_dbg;

  snap_t exp_q[$];
  snap_t prev_snap = '1;
  int    total = 0;
  int    bad = 0;
  bit    mon_en = 1'b0;
  int    wait_run = 0;
  int    last_wait_len = 0;

  song_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .btn_play    (btn_play),
    .btn_record  (btn_record),
    .btn_pause   (btn_pause),
    .btn_stop    (btn_stop),
    .sw_song     (sw_song),
    .loop_en     (loop_en),
    .ready       (ready),
    .song_done   (song_done),
    .start_song  (start_song),
    .pause_song  (pause_song),
    .record_mode (record_mode),
    .song_choice (song_choice),
    .state_dbg   (state_dbg),
    .done_pulse  (done_pulse),
    .err_pulse   (err_pulse)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input int st, input bit start, input bit pause,
                               input bit rec, input int choice, input bit done,
                               input bit err);
    snap_t s;
    s.state  = 3'(st);
    s.start  = start;
    s.pause  = pause;
    s.rec    = rec;
    s.choice = 4'(choice);
    s.done   = done;
    s.err    = err;
    return s;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: holds the given buttons for exactly one rising edge.
  task automatic applyStimulus(input bit play, input bit rec, input bit pause, input bit stop);
    btn_play = play; btn_record = rec; btn_pause = pause; btn_stop = stop;
    @(negedge clk);
    btn_play = 0; btn_record = 0; btn_pause = 0; btn_stop = 0;
  endtask

  task automatic ready_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      #2 ready = 1'b1;
      tick(4);
      #2 ready = 1'b0;
      tick(4);
    end
  endtask

  task automatic checkOutput(input snap_t got);
    snap_t want;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_change: got %h, required no change", got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL snapshot#%0d: got st=%0d start=%b pause=%b rec=%b ch=%0d done=%b err=%b, required st=%0d start=%b pause=%b rec=%b ch=%0d done=%b err=%b",
                 total, got.state, got.start, got.pause, got.rec, got.choice, got.done, got.err,
                 want.state, want.start, want.pause, want.rec, want.choice, want.done, want.err);
      end
    end
  endtask

  initial begin
    snap_t cur;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cur = {state_dbg, start_song, pause_song, record_mode, song_choice, done_pulse, err_pulse};
      if (cur !== prev_snap) begin
        prev_snap = cur;
        checkOutput(cur);
      end
    end
  end

  // Measures how many cycles each WAIT_ACK visit lasted.
  always @(negedge clk) begin
    if (state_dbg == 3'd2) wait_run++;
    else begin
      if (wait_run != 0) last_wait_len = wait_run;
      wait_run = 0;
    end
  end

  initial begin
    int guard;
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tick(3);
    mon_en = 1'b1;
    reset  = 1'b1;
    tick(2);

    // Record song 3 through START, WAIT_ACK into RUN.
    sw_song = 4'd3;
    exp_q.push_back(mk(1, 1, 1, 1, 3, 0, 0));
    applyStimulus(0, 1, 0, 0);
    exp_q.push_back(mk(2, 0, 1, 1, 3, 0, 0));
    ready_pulses(2);
    exp_q.push_back(mk(3, 0, 0, 1, 3, 0, 0));
    song_done = 1'b0;
    tick(2);

    // Stop beats song_done in RUN.
    exp_q.push_back(mk(0, 0, 1, 1, 3, 0, 0));
    song_done = 1'b1;
    applyStimulus(0, 0, 0, 1);
    tick(2);

    // Invalid codes raise a single-cycle error and leave latched values alone.
    sw_song = 4'd7;
    exp_q.push_back(mk(0, 0, 1, 1, 3, 0, 1));
    exp_q.push_back(mk(0, 0, 1, 1, 3, 0, 0));
    applyStimulus(1, 0, 0, 0);
    tick(2);
    sw_song = 4'd13;
    exp_q.push_back(mk(0, 0, 1, 1, 3, 0, 1));
    exp_q.push_back(mk(0, 0, 1, 1, 3, 0, 0));
    applyStimulus(1, 0, 0, 0);
    tick(2);

    // Looping playback of song 9 restarts after done.
    loop_en = 1'b1;
    sw_song = 4'd9;
    exp_q.push_back(mk(1, 1, 1, 0, 9, 0, 0));
    applyStimulus(1, 0, 0, 0);
    exp_q.push_back(mk(2, 0, 1, 0, 9, 0, 0));
    ready_pulses(2);
    exp_q.push_back(mk(3, 0, 0, 0, 9, 0, 0));
    song_done = 1'b0;
    tick(2);
    exp_q.push_back(mk(5, 0, 1, 0, 9, 1, 0));
    exp_q.push_back(mk(1, 1, 1, 0, 9, 0, 0));
    song_done = 1'b1;
    tick(3);
    exp_q.push_back(mk(2, 0, 1, 0, 9, 0, 0));
    ready_pulses(2);
    loop_en = 1'b0;

    // song_done stuck high: WAIT_ACK times out.
    exp_q.push_back(mk(0, 0, 1, 0, 9, 0, 1));
    exp_q.push_back(mk(0, 0, 1, 0, 9, 0, 0));
    guard = 0;
    while (state_dbg == 3'd2 && guard < 5000) begin
      tick();
      guard++;
    end
    tick(2);
    total++;
    if (last_wait_len != 4096) begin
      bad++;
      $display("[TB] FAIL ack_timeout_len: got %0d cycles, required 4096", last_wait_len);
    end

    // Pause / resume, song_done ignored while paused, then reset in PAUSED.
    sw_song = 4'd12;
    exp_q.push_back(mk(1, 1, 1, 0, 12, 0, 0));
    applyStimulus(1, 0, 0, 0);
    exp_q.push_back(mk(2, 0, 1, 0, 12, 0, 0));
    ready_pulses(2);
    exp_q.push_back(mk(3, 0, 0, 0, 12, 0, 0));
    song_done = 1'b0;
    tick(2);
    exp_q.push_back(mk(4, 0, 1, 0, 12, 0, 0));
    applyStimulus(0, 0, 1, 0);
    song_done = 1'b1;
    tick(2);
    song_done = 1'b0;
    exp_q.push_back(mk(3, 0, 0, 0, 12, 0, 0));
    applyStimulus(1, 0, 0, 0);
    tick();
    exp_q.push_back(mk(4, 0, 1, 0, 12, 0, 0));
    applyStimulus(0, 0, 1, 0);
    tick();
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick(2);

    // Play+record together records; pause ignored in START; stop aborts.
    song_done = 1'b1;
    sw_song = 4'd0;
    exp_q.push_back(mk(1, 1, 1, 1, 0, 0, 0));
    applyStimulus(1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0);
    tick();
    exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    applyStimulus(0, 0, 0, 1);
    tick(3);

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
